// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } ledMode_t;

  // A zero half-period would never terminate a count; it is treated as one tick.
  function automatic logic [31:0] effHalf(input logic [31:0] half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a registered one-cycle pulse every DIV clocks.
// The first pulse appears DIV cycles after reset release.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_gen: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count wraps after the terminal value; the pulse marks that wrap.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_q == LAST);
  end

  // Prescaler state and registered pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED driver: per-channel mode (off/on/blink/one-shot),
// half-period in timebase ticks and PWM brightness. A shared prescaler
// supplies the tick and a shared free-running counter the PWM base.
//
// Config interface: cfgWe is a single-cycle strobe with no back-pressure;
// every strobe with a legal cfgCh is accepted on the edge it is sampled.
// A write to a channel in the same cycle as a tick wins over the tick for
// that channel only. dbg_mode_o exposes each channel's mode state.
module led_blinker
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned PWM_W    = 8
) (
  input  logic                                               sysClk,
  input  logic                                               rstN,
  input  logic                                               cfgWe,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfgCh,
  input  logic [1:0]                                         cfgMode,
  input  logic [PERIOD_W-1:0]                                cfgHalf,
  input  logic [PWM_W-1:0]                                   cfgDuty,
  output logic [CHANNELS-1:0]                                led,
  output logic                                               tick,
  output logic [2*CHANNELS-1:0]                              dbg_mode_o
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("led_blinker: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_ch
    $error("led_blinker: CHANNELS must be >= 1");
  end

  // Per-channel state; widths depend on the module parameters.
  typedef struct packed {
    ledMode_t            mode;
    logic                phase;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] half;
    logic [PWM_W-1:0]    duty;
  } ledChan_t;

  logic             tick_w;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_i  (sysClk),
    .rst_ni (rstN),
    .tick_o (tick_w)
  );

  assign tick = tick_w;

  // PWM base counter wraps naturally at 2^PWM_W.
  always_comb pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

  // Free-running PWM base register.
  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    ledChan_t            ch_q, ch_d;
    ledMode_t            wr_mode;
    logic                wr_hit;
    logic                pwm_on;
    logic                led_q, led_d;
    logic [PERIOD_W-1:0] last_cnt;

    assign wr_mode  = ledMode_t'(cfgMode);
    // Out-of-range channel numbers match no channel, so such writes drop.
    assign wr_hit   = cfgWe && (cfgCh == CH_W'(i));
    assign last_cnt = PERIOD_W'(effHalf(32'(ch_q.half))) - PERIOD_W'(1);
    // All-ones duty is fully on; otherwise lit while the base is below duty.
    assign pwm_on   = (&ch_q.duty) || (pwm_cnt_q < ch_q.duty);
    assign led_d    = ch_q.phase & pwm_on;

    // Channel next state: a write restarts the channel and masks the tick.
    always_comb begin
      ch_d = ch_q;
      if (wr_hit) begin
        ch_d.mode  = wr_mode;
        ch_d.half  = cfgHalf;
        ch_d.duty  = cfgDuty;
        ch_d.cnt   = '0;
        ch_d.phase = (wr_mode != LED_OFF);
      end else if (tick_w) begin
        case (ch_q.mode)
          LED_BLINK: begin
            if (ch_q.cnt == last_cnt) begin
              ch_d.cnt   = '0;
              ch_d.phase = ~ch_q.phase;
            end else begin
              ch_d.cnt = ch_q.cnt + PERIOD_W'(1);
            end
          end
          LED_ONESHOT: begin
            if (ch_q.cnt == last_cnt) begin
              ch_d.cnt   = '0;
              ch_d.phase = 1'b0;
              ch_d.mode  = LED_OFF;
            end else begin
              ch_d.cnt = ch_q.cnt + PERIOD_W'(1);
            end
          end
          default: begin
            ch_d.cnt = '0;
          end
        endcase
      end
    end

    // Channel state and registered LED drive.
    always_ff @(posedge sysClk or negedge rstN) begin
      if (!rstN) begin
        ch_q  <= '0;
        led_q <= 1'b0;
      end else begin
        ch_q  <= ch_d;
        led_q <= led_d;
      end
    end

    assign led[i]              = led_q;
    assign dbg_mode_o[2*i +: 2] = ch_q.mode;
  end

endmodule
